a5: RTL and testbench
=====================

Name: a5

Overview:
- Crosspoint generator II for the AGC control datapath.
- Combines the one-hot instruction-phase decode with the 12 active-low time pulses to produce active-low register read/write control pulses for the central registers (A, B, C, G, L, U, Z, Y, S, Q).
- Also produces carry-in, sign/overflow/minus-zero test strobes and stage/sequence control.
- Outputs are registered once on CLOCK so downstream modules see glitch-free pulses.

Parameters:
- NT, 12, number of time pulses (T01..T12).
- NOP, 8, width of one-hot instruction decode vector.

Ports:
- CLOCK  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- T_n  in  12  time pulses T01_..T12_, bit i-1 = Ti, active low.
- OP  in  8  one-hot decode: [0]TC0 [1]TCF0 [2]TS0 [3]CCS0 [4]MASK0 [5]DAS0 [6]DXCH0 [7]RUPT0.
- BR1  in  1  branch bit 1 (sign result).
- BR2  in  1  branch bit 2 (overflow/zero result).
- GOJAM  in  1  global restart, active high.
- INKL_  in  1  counter-increment lockout, active low.
- PULSE_n  out  16  active-low pulses: [0]RA_ [1]RB_ [2]RC_ [3]RG_ [4]RL_ [5]RU_ [6]RZ_ [7]WA_ [8]WB_ [9]WG_ [10]WL_ [11]WS_ [12]WY_ [13]WY12_ [14]WZ_ [15]CI_.
- TOV_  out  1  overflow-test strobe, active low.
- TSGN_  out  1  sign-test strobe, active low.
- TMZ_  out  1  minus-zero-test strobe, active low.
- ST2_  out  1  set stage 2, active low.
- NISQ_  out  1  new-instruction-to-SQ request, active low.
- RSTSTG  out  1  reset stage counter, active high.

Behaviour:
- Reset (rst=0, asynchronous): all active-low outputs = 1; RSTSTG = 0. Held while rst=0. First CLOCK rising edge after release evaluates normally.
- Per rising edge: compute term(op,t) = OP[op] & ~T_n[t-1]. Each output register loads the OR of its terms. Active-low outputs load the inverse. Latency: exactly 1 cycle from inputs to outputs.
- Crosspoint table (pulse asserted when op and time pulse both active):
  - TC0: T01 RB,WY12,CI; T02 RZ,WS; T03 RU,WZ; T12 NISQ.
  - TCF0: T01 RB,WY12,CI; T03 RU,WZ; T12 NISQ.
  - TS0: T02 RA,WG; T05 TOV; T06 RZ,WY12,CI if BR1 or BR2; T07 RU,WZ if BR1 or BR2; T12 NISQ.
  - CCS0: T02 RG,WB; T05 TSGN,TMZ; T07 RB,WY; T08 RU,WZ; T12 NISQ.
  - MASK0: T02 RA,WY; T05 RG,WB; T07 RC,WA; T12 NISQ.
  - DAS0: T01 RL,WB; T05 RG,WY; T06 RU,WL; T12 ST2.
  - DXCH0: T02 RL,WB; T05 RG,WL; T08 RB,WG; T12 NISQ.
  - RUPT0: T01 RZ,WS; T03 RB,WZ; T12 NISQ.
- INKL_=0: all OP-derived terms suppressed (outputs inactive next cycle).
- GOJAM=1: all pulses inactive next cycle; RSTSTG=1 for each cycle GOJAM is sampled high. GOJAM has priority over everything except reset.
- Simultaneous decodes or time pulses (illegal upstream): no priority; outputs are the plain OR of every matching term.
- No T_n bit low, or OP=0: all outputs inactive.
- BR1/BR2 are sampled in the same cycle as the time pulse.

Optional Feature:
- Macro A5_MONITOR_EN.
- Defined: adds input MONWBK and output MONEX_ (active low, reset 1). When MONWBK=1 and T07 is low, WB_ and RG_ are asserted next cycle, and MONEX_ is asserted the same cycle. This is ORed with the normal table. GOJAM still suppresses these pulses.
- Undefined: neither port exists; behaviour is exactly the base table.

Decomposition:
- Package a5_pkg holds:
  - localparam indices for OP bits and PULSE_n bits;
  - time-pulse index constants T01..T12;
  - a typedef for the 16-bit pulse vector.
- One sub-module, a5_pulse_reg: async active-low reset register bank with per-bit reset value. It is instantiated for PULSE_n and for the strobe outputs.
- The crosspoint logic stays in a single always_comb.

Test Plan:
- Reset: rst=0 with OP=8'h01, T_n=12'hFFE → all active-low outputs 1, RSTSTG 0. Release rst → next edge PULSE_n=16'h5FFD (RB_, WY12_, CI_ low).
- TS0 branch: OP=8'h04, T06 low, BR1=0, BR2=0 → PULSE_n=16'hFFFF. Then BR2=1 → RZ_, WY12_, CI_ low one cycle later.
- CCS0 T05 → TSGN_=0, TMZ_=0, PULSE_n=16'hFFFF. CCS0 T12 → NISQ_=0 only.
- GOJAM=1 during DXCH0 T08 → PULSE_n=16'hFFFF, RSTSTG=1. GOJAM=0 → RB_, WG_ low.
- INKL_=0 with MASK0 T07 → all inactive. Sweep T01..T12 for each OP → each output matches the table, 1-cycle latency, and pulses last exactly as long as the time pulse.
- With A5_MONITOR_EN, MONWBK=1, OP=0, T07 low → WB_=0, RG_=0, MONEX_=0 next cycle.

Source files
------------

// File: rtl/a5_pkg.sv
// a5_pkg: shared constants for the a5 crosspoint generator.
//   - OP_* : bit positions in the one-hot instruction decode vector OP
//   - P_*  : bit positions in the active-low PULSE_n vector
//   - T01..T12 : bit positions of each time pulse in T_n
//   - S_*  : bit positions in the internal strobe register bank
//   - pulse_t : 16-bit pulse vector type
package a5_pkg;

    localparam int OP_TC0   = 0;
    localparam int OP_TCF0  = 1;
    localparam int OP_TS0   = 2;
    localparam int OP_CCS0  = 3;
    localparam int OP_MASK0 = 4;
    localparam int OP_DAS0  = 5;
    localparam int OP_DXCH0 = 6;
    localparam int OP_RUPT0 = 7;

    localparam int P_RA   = 0;
    localparam int P_RB   = 1;
    localparam int P_RC   = 2;
    localparam int P_RG   = 3;
    localparam int P_RL   = 4;
    localparam int P_RU   = 5;
    localparam int P_RZ   = 6;
    localparam int P_WA   = 7;
    localparam int P_WB   = 8;
    localparam int P_WG   = 9;
    localparam int P_WL   = 10;
    localparam int P_WS   = 11;
    localparam int P_WY   = 12;
    localparam int P_WY12 = 13;
    localparam int P_WZ   = 14;
    localparam int P_CI   = 15;
    localparam int PULSE_W = 16;

    localparam int T01 = 0;
    localparam int T02 = 1;
    localparam int T03 = 2;
    localparam int T04 = 3;
    localparam int T05 = 4;
    localparam int T06 = 5;
    localparam int T07 = 6;
    localparam int T08 = 7;
    localparam int T09 = 8;
    localparam int T10 = 9;
    localparam int T11 = 10;
    localparam int T12 = 11;

    // Strobe bank layout: five active-low strobes then the active-high RSTSTG.
    localparam int S_TOV    = 0;
    localparam int S_TSGN   = 1;
    localparam int S_TMZ    = 2;
    localparam int S_ST2    = 3;
    localparam int S_NISQ   = 4;
    localparam int S_RSTSTG = 5;
    localparam int STRB_N   = 5;

    typedef logic [PULSE_W-1:0] pulse_t;

endpackage

// File: rtl/a5_pulse_reg.sv
// a5_pulse_reg: register bank with asynchronous active-low reset and a
// per-bit reset value, used to deglitch the crosspoint outputs.
// Parameters:
//   W       - number of bits
//   RST_VAL - value each bit takes while reset is asserted
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous reset, active low
//   i_d     - next value
//   o_q     - registered value
module a5_pulse_reg #(
    parameter int           W       = 16,
    parameter logic [W-1:0] RST_VAL = '1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/a5.sv
// a5: crosspoint generator II. Combines the one-hot instruction-phase decode
// with the active-low time pulses to form registered, active-low register
// read/write pulses, carry-in, test strobes and stage/sequence control.
// Optional feature macro: A5_MONITOR_EN (adds MONWBK input and MONEX_ output).
// Ports:
//   CLOCK   - system clock
//   rst     - asynchronous reset, active low
//   T_n     - time pulses T01..T12, active low (bit i-1 = Ti)
//   OP      - one-hot decode TC0,TCF0,TS0,CCS0,MASK0,DAS0,DXCH0,RUPT0
//   BR1/BR2 - branch bits, sampled with the time pulse
//   GOJAM   - global restart, active high, overrides all pulses
//   INKL_   - counter-increment lockout, active low, blocks decode terms
//   PULSE_n - register control pulses, active low
//   TOV_, TSGN_, TMZ_, ST2_, NISQ_ - strobes, active low
//   RSTSTG  - reset stage counter, active high
//   MONWBK/MONEX_ - monitor write-back request / acknowledge (A5_MONITOR_EN)
module a5
    import a5_pkg::*;
#(
    parameter int NT  = 12,
    parameter int NOP = 8
) (
    input  logic           CLOCK,
    input  logic           rst,
    input  logic [NT-1:0]  T_n,
    input  logic [NOP-1:0] OP,
    input  logic           BR1,
    input  logic           BR2,
    input  logic           GOJAM,
    input  logic           INKL_,
`ifdef A5_MONITOR_EN
    input  logic           MONWBK,
    output logic           MONEX_,
`endif
    output pulse_t         PULSE_n,
    output logic           TOV_,
    output logic           TSGN_,
    output logic           TMZ_,
    output logic           ST2_,
    output logic           NISQ_,
    output logic           RSTSTG
);

`ifdef A5_MONITOR_EN
    localparam int           SW      = STRB_N + 2;
    localparam logic [SW-1:0] S_RST  = 7'b101_1111;
`else
    localparam int           SW      = STRB_N + 1;
    localparam logic [SW-1:0] S_RST  = 6'b01_1111;
`endif

    logic [NT-1:0]     w_t;
    logic [NOP-1:0]    w_op;
    logic              w_br;
    pulse_t            w_pulse;
    logic [STRB_N-1:0] w_strb;
    logic              w_mon;
    pulse_t            w_pulse_d;
    logic [SW-1:0]     w_strb_d;
    logic [SW-1:0]     w_strb_q;
    logic              w_unused;

    // Time pulses that no crosspoint uses.
    assign w_unused = ^{w_t[T04], w_t[T09], w_t[T10], w_t[T11]};

    always_comb begin
        w_t     = ~T_n;
        // The lockout kills every decode-derived term at the source.
        w_op    = INKL_ ? OP : '0;
        w_br    = BR1 | BR2;
        w_pulse = '0;
        w_strb  = '0;
        w_mon   = 1'b0;

        if (w_op[OP_TC0]) begin
            if (w_t[T01]) begin
                w_pulse[P_RB] = 1'b1; w_pulse[P_WY12] = 1'b1; w_pulse[P_CI] = 1'b1;
            end
            if (w_t[T02]) begin
                w_pulse[P_RZ] = 1'b1; w_pulse[P_WS] = 1'b1;
            end
            if (w_t[T03]) begin
                w_pulse[P_RU] = 1'b1; w_pulse[P_WZ] = 1'b1;
            end
            if (w_t[T12]) w_strb[S_NISQ] = 1'b1;
        end

        if (w_op[OP_TCF0]) begin
            if (w_t[T01]) begin
                w_pulse[P_RB] = 1'b1; w_pulse[P_WY12] = 1'b1; w_pulse[P_CI] = 1'b1;
            end
            if (w_t[T03]) begin
                w_pulse[P_RU] = 1'b1; w_pulse[P_WZ] = 1'b1;
            end
            if (w_t[T12]) w_strb[S_NISQ] = 1'b1;
        end

        if (w_op[OP_TS0]) begin
            if (w_t[T02]) begin
                w_pulse[P_RA] = 1'b1; w_pulse[P_WG] = 1'b1;
            end
            if (w_t[T05]) w_strb[S_TOV] = 1'b1;
            // Skip path only taken when the sign/overflow test fired.
            if (w_t[T06] && w_br) begin
                w_pulse[P_RZ] = 1'b1; w_pulse[P_WY12] = 1'b1; w_pulse[P_CI] = 1'b1;
            end
            if (w_t[T07] && w_br) begin
                w_pulse[P_RU] = 1'b1; w_pulse[P_WZ] = 1'b1;
            end
            if (w_t[T12]) w_strb[S_NISQ] = 1'b1;
        end

        if (w_op[OP_CCS0]) begin
            if (w_t[T02]) begin
                w_pulse[P_RG] = 1'b1; w_pulse[P_WB] = 1'b1;
            end
            if (w_t[T05]) begin
                w_strb[S_TSGN] = 1'b1; w_strb[S_TMZ] = 1'b1;
            end
            if (w_t[T07]) begin
                w_pulse[P_RB] = 1'b1; w_pulse[P_WY] = 1'b1;
            end
            if (w_t[T08]) begin
                w_pulse[P_RU] = 1'b1; w_pulse[P_WZ] = 1'b1;
            end
            if (w_t[T12]) w_strb[S_NISQ] = 1'b1;
        end

        if (w_op[OP_MASK0]) begin
            if (w_t[T02]) begin
                w_pulse[P_RA] = 1'b1; w_pulse[P_WY] = 1'b1;
            end
            if (w_t[T05]) begin
                w_pulse[P_RG] = 1'b1; w_pulse[P_WB] = 1'b1;
            end
            if (w_t[T07]) begin
                w_pulse[P_RC] = 1'b1; w_pulse[P_WA] = 1'b1;
            end
            if (w_t[T12]) w_strb[S_NISQ] = 1'b1;
        end

        if (w_op[OP_DAS0]) begin
            if (w_t[T01]) begin
                w_pulse[P_RL] = 1'b1; w_pulse[P_WB] = 1'b1;
            end
            if (w_t[T05]) begin
                w_pulse[P_RG] = 1'b1; w_pulse[P_WY] = 1'b1;
            end
            if (w_t[T06]) begin
                w_pulse[P_RU] = 1'b1; w_pulse[P_WL] = 1'b1;
            end
            // Double-precision add continues into stage 2 instead of fetching.
            if (w_t[T12]) w_strb[S_ST2] = 1'b1;
        end

        if (w_op[OP_DXCH0]) begin
            if (w_t[T02]) begin
                w_pulse[P_RL] = 1'b1; w_pulse[P_WB] = 1'b1;
            end
            if (w_t[T05]) begin
                w_pulse[P_RG] = 1'b1; w_pulse[P_WL] = 1'b1;
            end
            if (w_t[T08]) begin
                w_pulse[P_RB] = 1'b1; w_pulse[P_WG] = 1'b1;
            end
            if (w_t[T12]) w_strb[S_NISQ] = 1'b1;
        end

        if (w_op[OP_RUPT0]) begin
            if (w_t[T01]) begin
                w_pulse[P_RZ] = 1'b1; w_pulse[P_WS] = 1'b1;
            end
            if (w_t[T03]) begin
                w_pulse[P_RB] = 1'b1; w_pulse[P_WZ] = 1'b1;
            end
            if (w_t[T12]) w_strb[S_NISQ] = 1'b1;
        end

`ifdef A5_MONITOR_EN
        // Monitor write-back is not a decode term, so the lockout does not gate it.
        if (MONWBK && w_t[T07]) begin
            w_pulse[P_WB] = 1'b1;
            w_pulse[P_RG] = 1'b1;
            w_mon         = 1'b1;
        end
`endif

        // GOJAM forces every active-low output inactive and requests a stage reset.
        w_pulse_d = GOJAM ? '1 : ~w_pulse;
        w_strb_d  = S_RST;
        w_strb_d[STRB_N-1:0] = GOJAM ? '1 : ~w_strb;
        w_strb_d[S_RSTSTG]   = GOJAM;
`ifdef A5_MONITOR_EN
        w_strb_d[S_RSTSTG+1] = ~(w_mon & ~GOJAM);
`endif
    end

    a5_pulse_reg #(
        .W       (PULSE_W),
        .RST_VAL ('1)
    ) u_pulse_reg (
        .i_clk   (CLOCK),
        .i_rst_n (rst),
        .i_d     (w_pulse_d),
        .o_q     (PULSE_n)
    );

    a5_pulse_reg #(
        .W       (SW),
        .RST_VAL (S_RST)
    ) u_strb_reg (
        .i_clk   (CLOCK),
        .i_rst_n (rst),
        .i_d     (w_strb_d),
        .o_q     (w_strb_q)
    );

    assign TOV_   = w_strb_q[S_TOV];
    assign TSGN_  = w_strb_q[S_TSGN];
    assign TMZ_   = w_strb_q[S_TMZ];
    assign ST2_   = w_strb_q[S_ST2];
    assign NISQ_  = w_strb_q[S_NISQ];
    assign RSTSTG = w_strb_q[S_RSTSTG];
`ifdef A5_MONITOR_EN
    assign MONEX_ = w_strb_q[S_RSTSTG+1];
`endif

endmodule

// File: tb/tb_a5.sv
module tb_a5;

    // Pulse positions in PULSE_n.
    localparam int RA=0, RB=1, RC=2, RG=3, RL=4, RU=5, RZ=6, WA=7, WB=8, WG=9,
                   WL=10, WS=11, WY=12, WY12=13, WZ=14, CI=15;
    // Strobe positions in the compared strobe vector {RSTSTG,NISQ_,ST2_,TMZ_,TSGN_,TOV_}.
    localparam int ST_TOV=0, ST_TSGN=1, ST_TMZ=2, ST_ST2=3, ST_NISQ=4;

    logic        CLOCK = 1'b0;
    logic        rst;
    logic [11:0] T_n;
    logic [7:0]  OP;
    logic        BR1, BR2, GOJAM, INKL_;
    logic [15:0] PULSE_n;
    logic        TOV_, TSGN_, TMZ_, ST2_, NISQ_, RSTSTG;

    a5 dut (
        .CLOCK   (CLOCK),
        .rst     (rst),
        .T_n     (T_n),
        .OP      (OP),
        .BR1     (BR1),
        .BR2     (BR2),
        .GOJAM   (GOJAM),
        .INKL_   (INKL_),
        .PULSE_n (PULSE_n),
        .TOV_    (TOV_),
        .TSGN_   (TSGN_),
        .TMZ_    (TMZ_),
        .ST2_    (ST2_),
        .NISQ_   (NISQ_),
        .RSTSTG  (RSTSTG)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        int          op;
        int          t;
        logic [15:0] pm;
        logic [4:0]  sm;
        bit          br;
    } xp_t;

    typedef struct {
        logic [15:0] p;
        logic [5:0]  s;
    } exp_t;

    xp_t  tbl[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [15:0] m(input int a, input int b = -1, input int c = -1);
        logic [15:0] r = '0;
        r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        if (c >= 0) r[c] = 1'b1;
        return r;
    endfunction

    task automatic add(input int op, input int t, input logic [15:0] pm,
                       input logic [4:0] sm, input bit br = 0);
        xp_t e;
        e.op = op; e.t = t; e.pm = pm; e.sm = sm; e.br = br;
        tbl.push_back(e);
    endtask

    // Crosspoint table: one entry per (decode, time pulse) pair.
    task automatic build_table();
        logic [4:0] nisq = 5'b1 << ST_NISQ;
        add(0, 1, m(RB, WY12, CI), 0);  add(0, 2, m(RZ, WS), 0);
        add(0, 3, m(RU, WZ), 0);        add(0, 12, 0, nisq);
        add(1, 1, m(RB, WY12, CI), 0);  add(1, 3, m(RU, WZ), 0);
        add(1, 12, 0, nisq);
        add(2, 2, m(RA, WG), 0);        add(2, 5, 0, 5'b1 << ST_TOV);
        add(2, 6, m(RZ, WY12, CI), 0, 1); add(2, 7, m(RU, WZ), 0, 1);
        add(2, 12, 0, nisq);
        add(3, 2, m(RG, WB), 0);        add(3, 5, 0, (5'b1 << ST_TSGN) | (5'b1 << ST_TMZ));
        add(3, 7, m(RB, WY), 0);        add(3, 8, m(RU, WZ), 0);
        add(3, 12, 0, nisq);
        add(4, 2, m(RA, WY), 0);        add(4, 5, m(RG, WB), 0);
        add(4, 7, m(RC, WA), 0);        add(4, 12, 0, nisq);
        add(5, 1, m(RL, WB), 0);        add(5, 5, m(RG, WY), 0);
        add(5, 6, m(RU, WL), 0);        add(5, 12, 0, 5'b1 << ST_ST2);
        add(6, 2, m(RL, WB), 0);        add(6, 5, m(RG, WL), 0);
        add(6, 8, m(RB, WG), 0);        add(6, 12, 0, nisq);
        add(7, 1, m(RZ, WS), 0);        add(7, 3, m(RB, WZ), 0);
        add(7, 12, 0, nisq);
    endtask

    function automatic exp_t model(input logic [7:0] op, input logic [11:0] tn,
                                   input logic b1, input logic b2,
                                   input logic g, input logic k);
        exp_t        r;
        logic [15:0] pa = '0;
        logic [4:0]  sa = '0;
        foreach (tbl[i]) begin
            if (k && op[tbl[i].op] && !tn[tbl[i].t - 1] && (!tbl[i].br || b1 || b2)) begin
                pa |= tbl[i].pm;
                sa |= tbl[i].sm;
            end
        end
        if (g) begin
            r.p = 16'hFFFF;
            r.s = 6'h3F;
        end else begin
            r.p = ~pa;
            r.s = {1'b0, ~sa};
        end
        return r;
    endfunction

    function automatic logic [5:0] strb();
        return {RSTSTG, NISQ_, ST2_, TMZ_, TSGN_, TOV_};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_reset(input string name);
        chk({name, ".pulse"}, PULSE_n, 16'hFFFF);
        chk({name, ".strb"}, {10'h0, strb()}, 16'h001F);
    endtask

    task automatic drive(input logic [7:0] op, input logic [11:0] tn, input logic b1,
                         input logic b2, input logic g, input logic k);
        @(negedge CLOCK);
        OP = op; T_n = tn; BR1 = b1; BR2 = b2; GOJAM = g; INKL_ = k;
    endtask

    task automatic step_m(input logic [7:0] op, input logic [11:0] tn, input logic b1,
                          input logic b2, input logic g, input logic k);
        drive(op, tn, b1, b2, g, k);
        sb.push_back(model(op, tn, b1, b2, g, k));
    endtask

    task automatic step_x(input logic [7:0] op, input logic [11:0] tn, input logic b1,
                          input logic b2, input logic g, input logic k,
                          input logic [15:0] ep, input logic [5:0] es);
        exp_t e;
        drive(op, tn, b1, b2, g, k);
        e.p = ep; e.s = es;
        sb.push_back(e);
    endtask

    // Monitor: every queued expectation belongs to the next active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLOCK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pulse", PULSE_n, e.p);
                chk("strb", {10'h0, strb()}, {10'h0, e.s});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rop;
        logic [11:0] rtn;
        int          wait_cyc;
        exp_t        e;

        build_table();
        rst = 1'b0; OP = 8'h01; T_n = 12'hFFE;
        BR1 = 0; BR2 = 0; GOJAM = 0; INKL_ = 1;
        repeat (2) @(posedge CLOCK);
        #1 chk_reset("reset");

        // Release: the first edge evaluates TC0 at T01.
        @(negedge CLOCK);
        rst = 1'b1;
        e.p = 16'h5FFD; e.s = 6'h1F;
        sb.push_back(e);

        step_x(8'h04, 12'hFDF, 0, 0, 0, 1, 16'hFFFF, 6'h1F);   // TS0 T06 no branch
        step_x(8'h04, 12'hFDF, 0, 1, 0, 1, 16'h5FBF, 6'h1F);   // TS0 T06 BR2
        step_x(8'h08, 12'hFEF, 0, 0, 0, 1, 16'hFFFF, 6'h19);   // CCS0 T05
        step_x(8'h08, 12'h7FF, 0, 0, 0, 1, 16'hFFFF, 6'h0F);   // CCS0 T12
        step_x(8'h40, 12'hF7F, 0, 0, 1, 1, 16'hFFFF, 6'h3F);   // DXCH0 T08 GOJAM
        step_x(8'h40, 12'hF7F, 0, 0, 0, 1, 16'hFDFD, 6'h1F);   // DXCH0 T08
        step_x(8'h10, 12'hFBF, 0, 0, 0, 0, 16'hFFFF, 6'h1F);   // MASK0 T07 lockout
        step_x(8'h10, 12'hFBF, 0, 0, 0, 1, 16'hFF7B, 6'h1F);   // MASK0 T07
        step_x(8'h00, 12'hFBF, 1, 1, 0, 1, 16'hFFFF, 6'h1F);   // no decode
        step_x(8'hFF, 12'hFFF, 1, 1, 0, 1, 16'hFFFF, 6'h1F);   // no time pulse
        step_x(8'h21, 12'h7FF, 0, 0, 0, 1, 16'hFFFF, 6'h07);   // TC0|DAS0 T12: NISQ and ST2

        // Sweep every decode across every time pulse.
        for (int op = 0; op < 8; op++)
            for (int t = 0; t < 12; t++)
                step_m(8'b1 << op, ~(12'b1 << t), 1'($urandom), 1'($urandom), 0, 1);

        // Random traffic, mostly legal one-hot patterns with occasional illegal overlaps.
        for (int i = 0; i < 400; i++) begin
            rop = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'b1 << $urandom_range(0, 7));
            rtn = ($urandom_range(0, 3) == 0) ? 12'($urandom) : ~(12'b1 << $urandom_range(0, 11));
            step_m(rop, rtn, 1'($urandom), 1'($urandom),
                   $urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0);
        end

        // Asynchronous reset mid-run, with live pulses in the register.
        step_x(8'h01, 12'hFFE, 0, 0, 0, 1, 16'h5FFD, 6'h1F);
        @(posedge CLOCK);
        #3 rst = 1'b0;
        #1 chk_reset("async_reset");
        @(posedge CLOCK);
        #1 chk_reset("reset_hold");
        @(negedge CLOCK);
        rst = 1'b1;
        step_x(8'h80, 12'hFFB, 0, 0, 0, 1, 16'hBFFD, 6'h1F);   // RUPT0 T03
        step_m(8'h02, 12'hFFE, 0, 0, 0, 1);
        step_m(8'h00, 12'hFFF, 0, 0, 0, 1);

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(posedge CLOCK);
            wait_cyc++;
        end
        #2;
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
